// File: rtl/sram_mem_responder.sv
// Memory-side responder for the EXE/MEM boundary: turns one 32-bit word request
// into two halfword accesses on a 16-bit asynchronous SRAM, stalling the pipeline meanwhile.
module sram_mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'd1024,
   parameter int          WAIT_CYCLES = 4,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_out,
   input  logic [15:0]        SRAM_DQ_in,
   output logic               SRAM_DQ_oe,
   output logic               SRAM_WE_N
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int WW = SRAM_AW - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_LO,
      S_WR_HI,
      S_RD_LO,
      S_RD_HI,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [WW-1:0]   word_q;
   logic [15:0]     wr_hi_q;
   logic [WW-1:0]   word_idx;
   logic            phase_last;

   // Byte offset from the base, reduced to a word index; upper bits wrap silently.
   assign word_idx   = WW'((address - ADDR_BASE) >> 2);
   assign phase_last = (cnt_q == CW'(WAIT_CYCLES - 1));
   assign ready      = ~(wr_en | rd_en) | (state_q == S_DONE);

   // NOTE: every register, including the SRAM-facing outputs, uses non-blocking
   // assignment so the whole FSM updates atomically at the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         wr_hi_q     <= '0;
         read_data   <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_out <= '0;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_WE_N   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (wr_en) begin
                  state_q     <= S_WR_LO;
                  word_q      <= word_idx;
                  wr_hi_q     <= write_data[31:16];
                  SRAM_ADDR   <= {word_idx, 1'b0};
                  SRAM_DQ_out <= write_data[15:0];
                  SRAM_DQ_oe  <= 1'b1;
                  SRAM_WE_N   <= 1'b0;
               end else if (rd_en) begin
                  state_q    <= S_RD_LO;
                  word_q     <= word_idx;
                  SRAM_ADDR  <= {word_idx, 1'b0};
                  SRAM_DQ_oe <= 1'b0;
                  SRAM_WE_N  <= 1'b1;
               end
            end
            S_WR_LO: begin
               if (phase_last) begin
                  cnt_q       <= '0;
                  state_q     <= S_WR_HI;
                  SRAM_ADDR   <= {word_q, 1'b1};
                  SRAM_DQ_out <= wr_hi_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WR_HI: begin
               if (phase_last) begin
                  cnt_q      <= '0;
                  state_q    <= S_DONE;
                  SRAM_DQ_oe <= 1'b0;
                  SRAM_WE_N  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RD_LO: begin
               if (phase_last) begin
                  cnt_q           <= '0;
                  state_q         <= S_RD_HI;
                  read_data[15:0] <= SRAM_DQ_in;
                  SRAM_ADDR       <= {word_q, 1'b1};
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RD_HI: begin
               if (phase_last) begin
                  cnt_q            <= '0;
                  state_q          <= S_DONE;
                  read_data[31:16] <= SRAM_DQ_in;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // The pipeline advances on the DONE edge, so the next request appears in IDLE.
            S_DONE: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Self-checking bench for sram_mem_responder: directed vector table, reset/abort
// sequences, and randomized traffic against a word-level memory model.
module tb_sram_mem_responder;

   localparam int          W    = 4;
   localparam int          AW   = 18;
   localparam logic [31:0] BASE = 32'd1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en;
   logic [31:0]   address, write_data, read_data;
   logic          ready;
   logic [AW-1:0] SRAM_ADDR;
   logic [15:0]   SRAM_DQ_out, SRAM_DQ_in;
   logic          SRAM_DQ_oe, SRAM_WE_N;

   sram_mem_responder #(.ADDR_BASE(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .SRAM_ADDR   (SRAM_ADDR),
      .SRAM_DQ_out (SRAM_DQ_out),
      .SRAM_DQ_in  (SRAM_DQ_in),
      .SRAM_DQ_oe  (SRAM_DQ_oe),
      .SRAM_WE_N   (SRAM_WE_N)
   );

   always #5 clk = ~clk;

   // External SRAM: writes every cycle WE_N is low, read data settles by the falling edge.
   bit [15:0] sram [0:(1<<AW)-1];
   int        wr_cnt = 0;

   always @(posedge clk) begin
      if (!SRAM_WE_N) begin
         sram[SRAM_ADDR] <= SRAM_DQ_out;
         wr_cnt++;
      end
   end

   always @(negedge clk) SRAM_DQ_in = SRAM_DQ_oe ? 16'hxxxx : sram[SRAM_ADDR];

   // Word-level reference model.
   logic [31:0] ref_mem [int];
   logic [31:0] exp_rd = '0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge with the request already on the inputs (IDLE cycle).
   // Follows the access until ready rises, checking SRAM pins on every phase cycle.
   task automatic run_access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      int            stall;
      bit            ok;
      bit            hi;
      int            widx;
      logic [AW-1:0] lo_a;
      widx  = int'(((a - BASE) >> 2) & 32'h0001_FFFF);
      lo_a  = AW'(widx * 2);
      ok    = 1'b1;
      stall = 0;
      while (!ready && stall < 100) begin
         if (stall >= 1) begin
            hi = (stall > W);
            if (w)
               ok &= (SRAM_WE_N === 1'b0) && (SRAM_DQ_oe === 1'b1) &&
                     (SRAM_ADDR === lo_a + AW'(hi)) &&
                     (SRAM_DQ_out === (hi ? d[31:16] : d[15:0]));
            else
               ok &= (SRAM_WE_N === 1'b1) && (SRAM_DQ_oe === 1'b0) &&
                     (SRAM_ADDR === lo_a + AW'(hi));
         end
         stall++;
         @(negedge clk);
      end
      check("stall_cycles", stall, 2 * W + 1);
      check("phase_outputs", 32'(ok), 32'd1);
      if (w) ref_mem[widx] = d;
      else if (r) exp_rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
      check("read_data", read_data, exp_rd);
      check("done_strobes", {30'd0, SRAM_WE_N, SRAM_DQ_oe}, 32'd2);
      if (w) check("sram_word", {sram[lo_a + AW'(1)], sram[lo_a]}, d);
   endtask

   task automatic request(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en      = w;
      rd_en      = r;
      address    = a;
      write_data = d;
      #1;
      run_access(w, r, a, d);
   endtask

   typedef struct {
      bit          w;
      bit          r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [31:0] a, d;
      int          kind, wc;

      vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'h1234_ABCD, 32'h0000_0000};
      vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,         32'h1234_ABCD};
      vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h0000_0055, 32'h1234_ABCD};
      vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,         32'h0000_0055};
      vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'hCAFE_F00D, 32'h0000_0055};
      vecs[5] = '{1'b0, 1'b1, 32'd1032, 32'h0,         32'hCAFE_F00D};
      vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      vecs[7] = '{1'b0, 1'b1, 32'd1020 + 32'h0010_0000, 32'h0, 32'hDEAD_BEEF};

      // Reset held two cycles with a load pending.
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; write_data = '0;
      repeat (2) @(negedge clk);
      check("rst_read_data", read_data, 32'h0);
      check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      check("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
      check("rst_addr", 32'(SRAM_ADDR), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(ready), 32'd0);
      run_access(1'b0, 1'b1, 32'd1024, 32'h0);

      // Directed table, issued back-to-back with enables held continuously.
      for (int i = 0; i < 8; i++) begin
         request(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
         check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
      end
      check("sram_lo_1028", 32'(sram[2]), 32'h0000_ABCD);
      check("sram_hi_1028", 32'(sram[3]), 32'h0000_1234);
      check("sram_lo_1024", 32'(sram[0]), 32'h0000_0055);
      check("sram_hi_1024", 32'(sram[1]), 32'h0000_0000);

      // Idle with no enables: ready must be high.
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      check("idle_ready", 32'(ready), 32'd1);

      // Randomized traffic over a small window, with offset low bits and wrapped aliases.
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 2));
         a    = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)) +
                ($urandom_range(0, 1) ? 32'h0010_0000 : 32'h0);
         d    = $urandom;
         request(kind != 1, kind != 0, a, d);
         if ($urandom_range(0, 1)) begin
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
         end
      end

      // Reset asserted on the third cycle of the high write phase aborts the store.
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b0; address = BASE + 32'd160; write_data = 32'h5A5A_A5A5;
      repeat (W + 3) @(negedge clk);
      check("abort_in_wr_hi", {SRAM_WE_N, 31'(SRAM_ADDR)}, {1'b0, 31'd81});
      rst = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      check("abort_we_n", 32'(SRAM_WE_N), 32'd1);
      check("abort_oe", 32'(SRAM_DQ_oe), 32'd0);
      check("abort_read_data", read_data, 32'h0);
      wc  = wr_cnt;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_no_writes", 32'(wr_cnt), 32'(wc));
      check("abort_ready", 32'(ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
